// File: rtl/bip_pkg.sv
// Shared opcode, ACC-source and FSM encodings for the BIP fetch/decode stage.
package bip_pkg;

    localparam int DEF_INSBITS = 16;
    localparam int DEF_OPBITS  = 5;
    localparam int DEF_DTBITS  = 11;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

endpackage

// File: rtl/bip_fetch_decode_program_counter.sv
// Program counter register: increments on request, wraps naturally at 2^PCBITS.
module program_counter #(
    parameter int PCBITS = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_inc,
    output logic [PCBITS-1:0] o_pc
);

    logic [PCBITS-1:0] pc_q;
    logic [PCBITS-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (i_inc) begin
            pc_d = pc_q + PCBITS'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/bip_fetch_decode.sv
// BIP fetch/decode control: FETCH -> DECODE -> EXEC per instruction, stops on HLT.
module bip_fetch_decode
    import bip_pkg::*;
#(
    parameter int PCBITS  = 11,
    parameter int INSBITS = DEF_INSBITS,
    parameter int OPBITS  = DEF_OPBITS,
    parameter int DTBITS  = DEF_DTBITS,
    parameter int CNTBITS = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [INSBITS-1:0] i_instr,
    output logic [PCBITS-1:0]  o_pc_addr,
    output logic [DTBITS-1:0]  o_operand,
    output logic               o_wr_ram,
    output logic               o_rd_ram,
    output logic               o_wr_acc,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_op,
    output logic               o_halt,
    output logic [CNTBITS-1:0] o_cycles
);

    state_e               state_q, state_d;
    logic [INSBITS-1:0]   ir_q, ir_d;
    logic [CNTBITS-1:0]   cycles_q, cycles_d;
    logic                 pc_inc;
    logic                 exec_fire;
    logic [OPBITS-1:0]    opcode;
    logic                 dec_wr_ram, dec_rd_ram, dec_wr_acc;

    assign opcode = ir_q[INSBITS-1 -: OPBITS];

    program_counter #(
        .PCBITS (PCBITS)
    ) u_pc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (pc_inc),
        .o_pc    (o_pc_addr)
    );

    // Every transition, IR load and count step waits for i_enable.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cycles_d = cycles_q;
        pc_inc   = 1'b0;
        if (i_enable && (state_q != ST_HALTED)) begin
            cycles_d = cycles_q + CNTBITS'(1);
        end
        if (i_enable) begin
            case (state_q)
                ST_FETCH: state_d = ST_DECODE;
                ST_DECODE: begin
                    ir_d    = i_instr;
                    state_d = (i_instr[INSBITS-1 -: OPBITS] == OP_HLT) ? ST_HALTED : ST_EXEC;
                end
                ST_EXEC: begin
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_HALTED;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            cycles_q <= cycles_d;
        end
    end

    // Select lines follow IR at all times; only the strobes are qualified by EXEC.
    always_comb begin
        dec_wr_ram = 1'b0;
        dec_rd_ram = 1'b0;
        dec_wr_acc = 1'b0;
        o_sel_a    = SELA_MEM;
        o_sel_b    = 1'b0;
        o_op       = 1'b0;
        case (opcode)
            OP_STO: dec_wr_ram = 1'b1;
            OP_LD: begin
                dec_rd_ram = 1'b1;
                dec_wr_acc = 1'b1;
            end
            OP_LDI: begin
                dec_wr_acc = 1'b1;
                o_sel_a    = SELA_IMM;
            end
            OP_ADD, OP_SUB: begin
                dec_rd_ram = 1'b1;
                dec_wr_acc = 1'b1;
                o_sel_a    = SELA_ALU;
                o_op       = (opcode == OP_SUB);
            end
            OP_ADDI, OP_SUBI: begin
                dec_wr_acc = 1'b1;
                o_sel_a    = SELA_ALU;
                o_sel_b    = 1'b1;
                o_op       = (opcode == OP_SUBI);
            end
            default: ;
        endcase
    end

    assign exec_fire = (state_q == ST_EXEC) && i_enable;
    assign o_wr_ram  = dec_wr_ram & exec_fire;
    assign o_rd_ram  = dec_rd_ram & exec_fire;
    assign o_wr_acc  = dec_wr_acc & exec_fire;
    assign o_operand = ir_q[DTBITS-1:0];
    assign o_halt    = (state_q == ST_HALTED);
    assign o_cycles  = cycles_q;

endmodule
